reggy_skid: RTL and testbench

- Two-entry registered pipeline stage with a valid/ready handshake on both sides.
- It is the consuming end of a stage-to-stage transfer: it accepts data from an upstream producer and holds it until downstream takes it.
- A skid entry absorbs one extra beat when downstream stalls, so `in_ready` is a pure register output and no combinational ready path crosses stages.
- It sits between pipeline stages wherever a stage can stall. A synchronous flush squashes in-flight beats on a branch or hazard.

---
 rtl/reggy_skid.sv | 105 ++++++++++
 tb/tb_reggy_skid.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/reggy_skid.sv
// Two-entry registered pipeline stage (main + skid register) with valid/ready on both sides.
// Latency: one cycle from an accepted beat to out_valid when the stage was empty.
// Backpressure: in_ready is a flop; the skid entry absorbs the one beat sent while ready drops.
module reggy_skid #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out,
    output logic [1:0]   count
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [N-1:0] out_q, out_d;
    logic [N-1:0] skid_q, skid_d;
    logic         out_valid_q, out_valid_d;
    logic         in_ready_q, in_ready_d;
    logic [1:0]   count_q, count_d;

    logic acc;
    logic take;

    assign acc  = in_valid & in_ready_q;
    assign take = out_valid_q & out_ready;

    // Next-state and data-path selection; handshake flags are decoded from the next state
    // so every output port comes straight off a flop.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (acc) begin
                    out_d   = in;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (acc && take) begin
                    out_d = in;
                end else if (acc) begin
                    skid_d  = in;
                    state_d = FULL;
                end else if (take) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only a take can move the stage.
                if (take) begin
                    out_d   = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush squashes all held beats; data registers are left as don't-care.
        if (flush) begin
            state_d = EMPTY;
        end
        out_valid_d = (state_d != EMPTY);
        in_ready_d  = (state_d != FULL);
        case (state_d)
            ONE:     count_d = 2'd1;
            FULL:    count_d = 2'd2;
            default: count_d = 2'd0;
        endcase
    end

    // State and data registers with asynchronous reset to the empty stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            out_q       <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            count_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            count_q     <= count_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign count     = count_q;

endmodule

// File: tb/tb_reggy_skid.sv
module tb_reggy_skid;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_dat;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_dat;
    logic [1:0] count;

    int tests;
    int fails;
    logic [7:0] sb_q[$];

    reggy_skid #(.N(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_dat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out_dat),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: score the handshakes seen with the current inputs, then advance
    // to the next falling edge where outputs are stable and new inputs may be driven.
    task automatic tick();
        logic acc;
        logic take;
        logic [7:0] exp_dat;
        acc  = in_valid && in_ready && !rst;
        take = out_valid && out_ready && !rst;
        if (take) begin
            check("sb_nonempty", 8'(sb_q.size() > 0), 8'd1);
            if (sb_q.size() > 0) begin
                exp_dat = sb_q.pop_front();
                check("order", out_dat, exp_dat);
            end
        end
        if (flush) sb_q.delete();
        else if (acc) sb_q.push_back(in_dat);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b1;
        in_dat = 8'hA5;
        out_ready = 1'b0;

        // Reset held with a beat offered: nothing captured.
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", {7'd0, out_valid}, 8'd0);
        check("rst_in_ready", {7'd0, in_ready}, 8'd1);
        check("rst_count", {6'd0, count}, 8'd0);
        check("rst_out", out_dat, 8'h00);
        rst = 1'b0;
        tick();
        check("first_valid", {7'd0, out_valid}, 8'd1);
        check("first_out", out_dat, 8'hA5);
        check("first_count", {6'd0, count}, 8'd1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("drain_a5", {6'd0, count}, 8'd0);

        // Streaming at full throughput.
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_dat = 8'(i);
            tick();
            check("stream_out", out_dat, 8'(i));
            check("stream_count", {6'd0, count}, 8'd1);
            check("stream_in_ready", {7'd0, in_ready}, 8'd1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_empty", {7'd0, out_valid}, 8'd0);

        // Backpressure fills both entries.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_dat = 8'h10;
        tick();
        in_dat = 8'h11;
        tick();
        in_valid = 1'b0;
        check("bp_count", {6'd0, count}, 8'd2);
        check("bp_in_ready", {7'd0, in_ready}, 8'd0);
        check("bp_out", out_dat, 8'h10);
        tick();
        check("bp_hold_out", out_dat, 8'h10);
        check("bp_hold_valid", {7'd0, out_valid}, 8'd1);
        out_ready = 1'b1;
        tick();
        check("bp_second", out_dat, 8'h11);
        check("bp_ready_back", {7'd0, in_ready}, 8'd1);
        tick();
        check("bp_empty", {6'd0, count}, 8'd0);

        // Flush while full, with a beat offered that must never appear.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_dat = 8'h10;
        tick();
        in_dat = 8'h11;
        tick();
        flush = 1'b1;
        in_dat = 8'h22;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_count", {6'd0, count}, 8'd0);
        check("flush_valid", {7'd0, out_valid}, 8'd0);
        check("flush_in_ready", {7'd0, in_ready}, 8'd1);
        out_ready = 1'b1;
        tick();
        check("flush_no22", {7'd0, out_valid}, 8'd0);

        // Flush in ONE with an accepted beat: that beat is discarded too.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_dat = 8'h40;
        tick();
        flush = 1'b1;
        in_dat = 8'h41;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_acc_count", {6'd0, count}, 8'd0);
        out_ready = 1'b1;
        tick();
        check("flush_acc_novalid", {7'd0, out_valid}, 8'd0);

        // Asynchronous reset while full.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_dat = 8'h50;
        tick();
        in_dat = 8'h51;
        tick();
        in_valid = 1'b0;
        check("pre_rst_count", {6'd0, count}, 8'd2);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", {7'd0, out_valid}, 8'd0);
        check("arst_count", {6'd0, count}, 8'd0);
        check("arst_in_ready", {7'd0, in_ready}, 8'd1);
        check("arst_out", out_dat, 8'h00);
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        check("arst_no_deliver", {7'd0, out_valid}, 8'd0);

        // Accept and take in the same cycle while in ONE.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_dat = 8'h32;
        tick();
        out_ready = 1'b1;
        in_dat = 8'h33;
        tick();
        check("one_at_out", out_dat, 8'h33);
        check("one_at_count", {6'd0, count}, 8'd1);
        check("one_at_valid", {7'd0, out_valid}, 8'd1);
        in_valid = 1'b0;
        tick();

        // Random traffic with a toggling consumer, scored through the queue.
        for (int i = 0; i < 60; i++) begin
            in_valid = 1'($urandom_range(1, 0));
            out_ready = 1'($urandom_range(1, 0));
            in_dat = 8'($urandom_range(255, 0));
            tick();
            check("rand_count", {6'd0, count}, 8'(sb_q.size()));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        check("drained", 8'(sb_q.size()), 8'd0);
        check("drained_valid", {7'd0, out_valid}, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
